l15_req_port_arbiter: RTL

- Shares the single L1.5 request channel between the per-port requesters of the HPDC/I$ subsystem adapter: I$ miss, D$ miss-read, write-buffer, UC read, UC write and AMO.
- Fixed priority, port 0 highest, with per-port starvation promotion.
- The grant is locked until the L1.5 accepts the request.
- Caps in-flight transactions with an outstanding-credit counter that is decremented by L1.5 returns.

---
 rtl/l15_req_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/l15_req_port_arbiter.sv
// L1.5 request-channel arbiter: fixed priority with starvation promotion,
// grant held until L1.5 ack, in-flight transactions capped by a credit counter.
//
// state | meaning
// IDLE  | no request presented; pick a winner among eligible ports
// GRANT | l15_val_o high for l15_portid_o; wait for l15_ack_i
module l15_req_port_arbiter #(
    parameter int NumPorts       = 6,
    parameter int StarveTh       = 8,
    parameter int MaxOutstanding = 4,
    parameter int PortIdWidth    = $clog2(NumPorts),
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NumPorts-1:0]    req_valid_i,
    output logic [NumPorts-1:0]    req_ready_o,
    output logic                   l15_val_o,
    output logic [PortIdWidth-1:0] l15_portid_o,
    input  logic                   l15_ack_i,
    input  logic                   rtrn_valid_i,
    output logic [CntWidth-1:0]    outstanding_o,
    output logic [NumPorts-1:0]    starved_o,
    output logic                   err_o
);

    localparam logic [CntWidth-1:0] MaxCnt    = CntWidth'(MaxOutstanding);
    localparam logic [7:0]          StarveCnt = 8'(StarveTh);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e                 state_q, state_d;
    logic [PortIdWidth-1:0] portid_q, portid_d;
    logic [CntWidth-1:0]    outstanding_q;
    logic [7:0]             starve_cnt_q [NumPorts];
    logic                   err_q;
    logic [NumPorts-1:0]    eligible;
    logic [NumPorts-1:0]    starved;
    logic [PortIdWidth-1:0] winner;
    logic                   ack_fire;

    // Eligibility uses the registered count, so a same-cycle return frees
    // its credit only from the following cycle.
    always_comb begin
        starved  = '0;
        winner   = '0;
        for (int p = 0; p < NumPorts; p++) begin
            starved[p] = (starve_cnt_q[p] == StarveCnt);
        end
        eligible = req_valid_i & {NumPorts{outstanding_q < MaxCnt}};
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (eligible[i]) winner = PortIdWidth'(i);
        end
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (eligible[i] && starved[i]) winner = PortIdWidth'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        portid_d    = portid_q;
        ack_fire    = 1'b0;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d  = GRANT;
                    portid_d = winner;
                end
            end
            GRANT: begin
                if (l15_ack_i) begin
                    ack_fire = rstn_i;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        for (int p = 0; p < NumPorts; p++) begin
            req_ready_o[p] = ack_fire && (portid_q == PortIdWidth'(p));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            portid_q <= '0;
        end else begin
            state_q  <= state_d;
            portid_q <= portid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            case ({ack_fire, rtrn_valid_i})
                2'b10: outstanding_q <= outstanding_q + CntWidth'(1);
                2'b01: begin
                    if (outstanding_q == '0) err_q <= 1'b1;
                    else outstanding_q <= outstanding_q - CntWidth'(1);
                end
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Losers still requesting age by one per accepted grant; the winner restarts.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumPorts; p++) begin
            if (!rstn_i) begin
                starve_cnt_q[p] <= '0;
            end else if (ack_fire) begin
                if (portid_q == PortIdWidth'(p)) begin
                    starve_cnt_q[p] <= '0;
                end else if (req_valid_i[p] && (starve_cnt_q[p] != StarveCnt)) begin
                    starve_cnt_q[p] <= starve_cnt_q[p] + 8'd1;
                end
            end
        end
    end

    assign l15_val_o     = (state_q == GRANT);
    assign l15_portid_o  = portid_q;
    assign outstanding_o = outstanding_q;
    assign starved_o     = starved;
    assign err_o         = err_q;

endmodule
